reg_inuse_tracker: RTL and testbench



---
 rtl/reg_inuse_tracker_pkg.sv | 19 +
 rtl/reg_inuse_retire_match.sv | 33 +++
 rtl/reg_inuse_tracker.sv | 155 +++++++++++++++
 tb/tb_reg_inuse_tracker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_inuse_tracker_pkg.sv
// Shared types for the register in-use scoreboard: sweep FSM states, entry layout
// and default sizing.
package cva5_types;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ID_W_DEF     = 3;
  localparam int unsigned REG_ADDR_W   = $clog2(NUM_REGS_DEF);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } reg_inuse_state_t;

  typedef struct packed {
    logic                inuse;
    logic [ID_W_DEF-1:0] tag;
  } reg_inuse_entry_t;

endpackage

// File: rtl/reg_inuse_retire_match.sv
// Per-register clear vector: an entry clears when any valid retire port names it
// with the producer tag it currently holds. Shared by state update and bypass.
module reg_inuse_retire_match
  import cva5_types::*;
#(
  parameter int unsigned NUM_REGS         = NUM_REGS_DEF,
  parameter int unsigned NUM_RETIRE_PORTS = 2,
  parameter int unsigned ID_W             = ID_W_DEF,
  parameter int unsigned ADDR_W           = $clog2(NUM_REGS)
) (
  input  logic                                         i_en,
  input  logic [NUM_REGS-1:0]                          i_inuse,
  input  logic [NUM_REGS-1:0][ID_W-1:0]                i_tag,
  input  logic [NUM_RETIRE_PORTS-1:0]                  i_retire_valid,
  input  logic [NUM_RETIRE_PORTS-1:0][ADDR_W-1:0]      i_retire_rd_addr,
  input  logic [NUM_RETIRE_PORTS-1:0][ID_W-1:0]        i_retire_id,
  output logic [NUM_REGS-1:0]                          o_clear
);

  // OR-reduce tag-matched hits from every retire port into each register's clear bit
  always_comb begin
    o_clear = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int r = 0; r < NUM_RETIRE_PORTS; r++) begin
        o_clear[i] = o_clear[i] |
                     (i_en && i_inuse[i] && i_retire_valid[r] &&
                      (i_retire_rd_addr[r] == ADDR_W'(i)) &&
                      (i_retire_id[r] == i_tag[i]));
      end
    end
  end

endmodule

// File: rtl/reg_inuse_tracker.sv
// Register in-use scoreboard with producer tags and a built-in init/flush sweep.
// Define REG_INUSE_RETIRE_BYPASS_EN to let a matching retire mask lookups in the same cycle.
module reg_inuse_tracker
  import cva5_types::*;
#(
  parameter int unsigned NUM_REGS         = NUM_REGS_DEF,
  parameter int unsigned NUM_READ_PORTS   = 2,
  parameter int unsigned NUM_RETIRE_PORTS = 2,
  parameter int unsigned ID_W             = ID_W_DEF,
  parameter bit          ZERO_REG_EN      = 1'b1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush,
  output logic                                              ready,
  input  logic                                              issued,
  input  logic [$clog2(NUM_REGS)-1:0]                       issued_rd_addr,
  input  logic [ID_W-1:0]                                   issued_id,
  input  logic [NUM_RETIRE_PORTS-1:0]                       retire_valid,
  input  logic [NUM_RETIRE_PORTS-1:0][$clog2(NUM_REGS)-1:0] retire_rd_addr,
  input  logic [NUM_RETIRE_PORTS-1:0][ID_W-1:0]             retire_id,
  input  logic [NUM_READ_PORTS-1:0][$clog2(NUM_REGS)-1:0]   rs_addr,
  output logic [NUM_READ_PORTS-1:0]                         rs_inuse,
  output logic [NUM_READ_PORTS-1:0][ID_W-1:0]               rs_id
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  reg_inuse_state_t              r_state;
  logic [ADDR_W-1:0]             r_cnt;
  logic                          r_ready;
  logic [NUM_REGS-1:0]           r_inuse;
  logic [NUM_REGS-1:0][ID_W-1:0] r_tag;
  logic [NUM_REGS-1:0]           w_clear;
  logic [NUM_REGS-1:0]           w_bypass;
  logic                          w_active;

  assign w_active = (r_state == READY);
  assign ready    = r_ready;

  reg_inuse_retire_match #(
    .NUM_REGS         (NUM_REGS),
    .NUM_RETIRE_PORTS (NUM_RETIRE_PORTS),
    .ID_W             (ID_W),
    .ADDR_W           (ADDR_W)
  ) u_retire_match (
    .i_en             (w_active),
    .i_inuse          (r_inuse),
    .i_tag            (r_tag),
    .i_retire_valid   (retire_valid),
    .i_retire_rd_addr (retire_rd_addr),
    .i_retire_id      (retire_id),
    .o_clear          (w_clear)
  );

`ifdef REG_INUSE_RETIRE_BYPASS_EN
  assign w_bypass = w_clear;
`else
  assign w_bypass = '0;
`endif

  // Sweep FSM and entry update; issue takes priority over a same-cycle matching retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_inuse <= '0;
      r_tag   <= '0;
    end else if (flush) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_inuse[r_cnt] <= 1'b0;
          r_tag[r_cnt]   <= '0;
          r_cnt          <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (issued && (issued_rd_addr == ADDR_W'(i)) && !(ZERO_REG_EN && (i == 0))) begin
              r_inuse[i] <= 1'b1;
              r_tag[i]   <= issued_id;
            end else if (w_clear[i]) begin
              r_inuse[i] <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Source lookups; everything reads busy while the sweep is running
  always_comb begin
    rs_inuse = '0;
    rs_id    = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (w_active) begin
        rs_inuse[p] = r_inuse[rs_addr[p]] & ~w_bypass[rs_addr[p]];
        rs_id[p]    = r_tag[rs_addr[p]];
      end else begin
        rs_inuse[p] = 1'b1;
        rs_id[p]    = '0;
      end
      if (ZERO_REG_EN && (rs_addr[p] == '0)) begin
        rs_inuse[p] = 1'b0;
      end else begin
        rs_inuse[p] = rs_inuse[p];
      end
    end
  end

`ifndef SYNTHESIS
  logic w_dbg_inuse [NUM_REGS];

  // Unpacked view of all in-use bits for waveform and bench inspection
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_dbg_inuse[i] = r_inuse[i];
    end
  end

  reg_inuse_tracker_chk u_chk (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ready  (r_ready),
    .i_issued (issued)
  );
`endif

endmodule

// Protocol checker: the issue stage must stall until the clear sweep is done.
module reg_inuse_tracker_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_ready,
  input logic i_issued
);

  a_issue_when_ready: assert property (@(posedge i_clk) disable iff (i_rst) i_issued |-> i_ready)
    else $error("issued asserted while tracker not ready");

endmodule

// File: tb/tb_reg_inuse_tracker.sv
// Scoreboard bench for reg_inuse_tracker: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_inuse_tracker;

`ifdef REG_INUSE_RETIRE_BYPASS_EN
  localparam int RET_SAME = 0;
`else
  localparam int RET_SAME = 1;
`endif

  localparam int K_READY = 0;
  localparam int K_INUSE = 1;
  localparam int K_ID    = 2;
  localparam int K_DBG   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            ready;
  logic            issued;
  logic [4:0]      issued_rd_addr;
  logic [2:0]      issued_id;
  logic [1:0]      retire_valid;
  logic [1:0][4:0] retire_rd_addr;
  logic [1:0][2:0] retire_id;
  logic [1:0][4:0] rs_addr;
  logic [1:0]      rs_inuse;
  logic [1:0][2:0] rs_id;

  typedef struct {
    int    cyc;
    string name;
    int    kind;
    int    p;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_inuse_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ready          (ready),
    .issued         (issued),
    .issued_rd_addr (issued_rd_addr),
    .issued_id      (issued_id),
    .retire_valid   (retire_valid),
    .retire_rd_addr (retire_rd_addr),
    .retire_id      (retire_id),
    .rs_addr        (rs_addr),
    .rs_inuse       (rs_inuse),
    .rs_id          (rs_id)
  );

  task automatic push(input string name, input int kind, input int p, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.kind = kind;
    e.p    = p;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rd, input int id);
    issued         = 1'b1;
    issued_rd_addr = 5'(rd);
    issued_id      = 3'(id);
  endtask

  task automatic retire(input int port, input int rd, input int id);
    retire_valid[port]   = 1'b1;
    retire_rd_addr[port] = 5'(rd);
    retire_id[port]      = 3'(id);
  endtask

  // Monitor: compare every expectation queued for the current cycle
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        case (e.kind)
          K_READY: act = int'(ready);
          K_INUSE: act = int'(rs_inuse[e.p]);
          K_ID:    act = int'(rs_id[e.p]);
          default: begin
            act = 0;
            for (int i = 0; i < 32; i++) act += int'(dut.w_dbg_inuse[i]);
          end
        endcase
        n_checks++;
        if (e.cyc != cyc)
          $display("FAIL %s: expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
        else if (act == e.val)
          n_pass++;
        else
          $display("FAIL %s: got %0d, expected %0d", e.name, act, e.val);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    issued         = 1'b0;
    issued_rd_addr = '0;
    issued_id      = '0;
    retire_valid   = '0;
    retire_rd_addr = '0;
    retire_id      = '0;
    rs_addr        = '0;

    // Reset, release, reassert in the middle of the sweep, release again
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    push("ready_in_rst", K_READY, 0, 0);
    step();
    rst = 1'b0;
    rs_addr[0] = 5'd5;
    rs_addr[1] = 5'd0;
    push("init_ready", K_READY, 0, 0);
    push("init_stall", K_INUSE, 0, 1);
    push("init_id", K_ID, 0, 0);
    push("init_zero_reg", K_INUSE, 1, 0);
    for (int i = 1; i < 32; i++) begin
      step();
      push("init_ready", K_READY, 0, 0);
      push("init_stall", K_INUSE, 0, 1);
    end
    step();
    push("ready_rise", K_READY, 0, 1);
    push("post_init_inuse", K_INUSE, 0, 0);
    push("post_init_id", K_ID, 0, 0);

    // Issue rd5/id3, retire on port 1
    issue(5, 3);
    push("issue5_pre", K_INUSE, 0, 0);
    step();
    issued = 1'b0;
    push("issue5_inuse", K_INUSE, 0, 1);
    push("issue5_id", K_ID, 0, 3);
    retire(1, 5, 3);
    push("retire5_same", K_INUSE, 0, RET_SAME);
    step();
    retire_valid = '0;
    push("retire5_after", K_INUSE, 0, 0);

    // WAW: a stale retire must not clear the newer claim
    rs_addr[0] = 5'd7;
    issue(7, 1);
    step();
    issue(7, 2);
    push("waw_first", K_INUSE, 0, 1);
    push("waw_first_id", K_ID, 0, 1);
    step();
    issued = 1'b0;
    push("waw_second", K_INUSE, 0, 1);
    push("waw_second_id", K_ID, 0, 2);
    retire(0, 7, 1);
    push("waw_stale_same", K_INUSE, 0, 1);
    step();
    retire_valid = '0;
    push("waw_stale_after", K_INUSE, 0, 1);
    push("waw_stale_id", K_ID, 0, 2);
    retire(0, 7, 2);
    push("waw_match_same", K_INUSE, 0, RET_SAME);
    step();
    retire_valid = '0;
    push("waw_cleared", K_INUSE, 0, 0);

    // Issue and matching retire to the same register in one cycle: issue wins
    rs_addr[0] = 5'd9;
    issue(9, 2);
    step();
    issued = 1'b0;
    push("same_setup", K_INUSE, 0, 1);
    push("same_setup_id", K_ID, 0, 2);
    issue(9, 4);
    retire(1, 9, 2);
    push("same_cycle_lookup", K_INUSE, 0, RET_SAME);
    push("same_cycle_id", K_ID, 0, 2);
    step();
    issued       = 1'b0;
    retire_valid = '0;
    push("same_issue_wins", K_INUSE, 0, 1);
    push("same_issue_wins_id", K_ID, 0, 4);

    // Two ports clear different registers in the same cycle
    issue(3, 5);
    step();
    issue(12, 6);
    step();
    issued = 1'b0;
    rs_addr[0] = 5'd3;
    rs_addr[1] = 5'd12;
    push("dual_set3", K_INUSE, 0, 1);
    push("dual_set12", K_INUSE, 1, 1);
    push("dual_id3", K_ID, 0, 5);
    push("dual_id12", K_ID, 1, 6);
    retire(0, 3, 5);
    retire(1, 12, 6);
    push("dual_same3", K_INUSE, 0, RET_SAME);
    push("dual_same12", K_INUSE, 1, RET_SAME);
    step();
    retire_valid = '0;
    push("dual_clear3", K_INUSE, 0, 0);
    push("dual_clear12", K_INUSE, 1, 0);

    // Both ports retire the same register with a matching tag
    rs_addr[0] = 5'd4;
    issue(4, 1);
    step();
    issued = 1'b0;
    push("both_ports_set", K_INUSE, 0, 1);
    retire(0, 4, 1);
    retire(1, 4, 1);
    step();
    retire_valid = '0;
    push("both_ports_clear", K_INUSE, 0, 0);

    // Register 0 is never claimed
    rs_addr[0] = 5'd0;
    issue(0, 7);
    step();
    issued = 1'b0;
    push("zero_reg", K_INUSE, 0, 0);
    push("zero_reg_id", K_ID, 0, 0);

    // Flush with registers 1..10 in use
    for (int r = 1; r <= 10; r++) begin
      issue(r, r % 8);
      step();
    end
    issued = 1'b0;
    rs_addr[0] = 5'd10;
    rs_addr[1] = 5'd1;
    push("pre_flush10", K_INUSE, 0, 1);
    push("pre_flush10_id", K_ID, 0, 2);
    push("pre_flush1", K_INUSE, 1, 1);
    push("pre_flush1_id", K_ID, 1, 1);
    flush = 1'b1;
    push("ready_before_flush", K_READY, 0, 1);
    step();
    flush = 1'b0;
    push("flush_ready_drop", K_READY, 0, 0);
    push("flush_stall", K_INUSE, 0, 1);
    push("flush_id", K_ID, 0, 0);
    for (int i = 1; i < 32; i++) begin
      step();
      push("flush_ready", K_READY, 0, 0);
    end
    step();
    push("flush_ready_back", K_READY, 0, 1);
    push("flush_clear10", K_INUSE, 0, 0);
    push("flush_clear1", K_INUSE, 1, 0);
    push("flush_all_clear", K_DBG, 0, 0);
    rs_addr[1] = 5'd2;
    issue(2, 3);
    step();
    issued = 1'b0;
    push("post_flush_issue", K_INUSE, 1, 1);
    push("post_flush_issue_id", K_ID, 1, 3);

    step();
    step();
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
